// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the test-picture generator: pattern modes, colour-bar
// masks and the bar-index helper.
package vga_pattern_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_BARS     = 3'd1,
    MODE_CHECKER  = 3'd2,
    MODE_GRADIENT = 3'd3,
    MODE_SCROLL   = 3'd4
  } mode_e;

  // {r,g,b} full-scale flags per bar, index 7 leftmost:
  // white, yellow, cyan, green, magenta, red, blue, black for indices 0..7.
  localparam logic [7:0][2:0] BAR_MASK = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  // floor(x*8/res_x) built from seven threshold compares; with res_x a
  // constant each compare folds to a comparison against a fixed value.
  function automatic logic [2:0] bar_index(input int unsigned x, input int unsigned res_x);
    logic [2:0] b;
    b = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x * 8 >= k * res_x) b = 3'(k);
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_rate_meter.sv
// Counts fetch_next pulses in rate units over a fixed gate window and reports
// the saturated total once per window.
module pixel_rate_meter #(
  parameter int unsigned c_gate_cycles = 65000000,
  parameter int unsigned c_rate_div    = 1000000
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       fetch_next,
  output logic [7:0] rate_count,
  output logic       rate_valid
);

  localparam int unsigned GW = $clog2(c_gate_cycles + 1);
  localparam int unsigned DW = $clog2(c_rate_div + 1);

  logic [GW-1:0] gate_q;
  logic [DW-1:0] div_q;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    rate_count_q;
  logic          rate_valid_q;
  logic          gate_last, div_wrap;

  always_comb begin
    gate_last = (gate_q == GW'(c_gate_cycles - 1));
    div_wrap  = fetch_next && (div_q == DW'(c_rate_div - 1));
    // The increment from the final gate cycle still lands in the report.
    acc_d     = (div_wrap && acc_q != 8'hFF) ? acc_q + 8'd1 : acc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      gate_q       <= '0;
      div_q        <= '0;
      acc_q        <= '0;
      rate_count_q <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      gate_q <= gate_last ? '0 : gate_q + 1'b1;
      if (gate_last) begin
        acc_q        <= '0;
        div_q        <= '0;
        rate_count_q <= acc_d;
        rate_valid_q <= 1'b1;
      end else begin
        acc_q        <= acc_d;
        rate_valid_q <= 1'b0;
        if (fetch_next) div_q <= div_wrap ? '0 : div_q + 1'b1;
      end
    end
  end

  assign rate_count = rate_count_q;
  assign rate_valid = rate_valid_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-picture pixel source: one registered RGB pixel per fetch_next, with
// active-area position tracking, a frame counter and a pixel-rate meter.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int unsigned c_resolution_x = 1920,
  parameter int unsigned c_resolution_y = 1080,
  parameter int unsigned c_bits_x       = 11,
  parameter int unsigned c_bits_y       = 11,
  parameter int unsigned c_color_bits   = 8,
  parameter int unsigned c_checker_log2 = 5,
  parameter int unsigned c_gate_cycles  = 65000000,
  parameter int unsigned c_rate_div     = 1000000
) (
  input  logic                      clk_pixel,
  input  logic                      rst_n,
  input  logic                      fetch_next,
  input  logic [2:0]                mode_i,
  input  logic [3*c_color_bits-1:0] solid_rgb_i,
  output logic [c_color_bits-1:0]   out_red,
  output logic [c_color_bits-1:0]   out_green,
  output logic [c_color_bits-1:0]   out_blue,
  output logic [c_bits_x-1:0]       out_x,
  output logic [c_bits_y-1:0]       out_y,
  output logic                      frame_start,
  output logic [7:0]                rate_count,
  output logic                      rate_valid
);

  localparam int unsigned CB = c_color_bits;

  logic [c_bits_x-1:0] x_q, x_d;
  logic [c_bits_y-1:0] y_q, y_d;
  logic [7:0]          frame_q, frame_d;
  mode_e               mode_q, mode_d;
  logic                last_x, last_y;

  logic [2:0]          bar, scroll_idx;
  logic [3*CB-1:0]     rgb_d, rgb_q;
  logic [c_bits_x-1:0] out_x_q;
  logic [c_bits_y-1:0] out_y_q;
  logic                frame_start_q;

  assign last_x = (x_q == c_bits_x'(c_resolution_x - 1));
  assign last_y = (y_q == c_bits_y'(c_resolution_y - 1));

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    if (fetch_next) begin
      if (last_x) begin
        x_d = '0;
        if (last_y) begin
          y_d     = '0;
          frame_d = frame_q + 8'd1;
          mode_d  = mode_e'(mode_i);
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    bar        = bar_index(32'(x_q), c_resolution_x);
    scroll_idx = bar + frame_q[2:0];
    rgb_d      = '0;
    case (mode_q)
      MODE_SOLID:    rgb_d = solid_rgb_i;
      MODE_BARS:     rgb_d = {{CB{BAR_MASK[bar][2]}}, {CB{BAR_MASK[bar][1]}},
                              {CB{BAR_MASK[bar][0]}}};
      MODE_CHECKER:  rgb_d = {(3*CB){x_q[c_checker_log2] ^ y_q[c_checker_log2]}};
      MODE_GRADIENT: rgb_d = {CB'(x_q), CB'(y_q), CB'(frame_q)};
      MODE_SCROLL:   rgb_d = {{CB{BAR_MASK[scroll_idx][2]}}, {CB{BAR_MASK[scroll_idx][1]}},
                              {CB{BAR_MASK[scroll_idx][0]}}};
      default:       rgb_d = '0;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_q       <= '0;
      mode_q        <= MODE_SOLID;
      rgb_q         <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      frame_start_q <= fetch_next && (x_q == '0) && (y_q == '0);
      if (fetch_next) begin
        rgb_q   <= rgb_d;
        out_x_q <= x_q;
        out_y_q <= y_q;
      end
    end
  end

  assign out_red     = rgb_q[3*CB-1:2*CB];
  assign out_green   = rgb_q[2*CB-1:CB];
  assign out_blue    = rgb_q[CB-1:0];
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign frame_start = frame_start_q;

  pixel_rate_meter #(
    .c_gate_cycles(c_gate_cycles),
    .c_rate_div   (c_rate_div)
  ) u_rate_meter (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .fetch_next(fetch_next),
    .rate_count(rate_count),
    .rate_valid(rate_valid)
  );

endmodule
